// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX controller, the RX path and the parity
// calculator.
//   DATA_W            : serial payload width in bits
//   PAR_EVEN/PAR_ODD  : encoding of par_type / parity_type
//   uart_state_e      : frame sequencing states
package uart_pkg;

    localparam int   DATA_W   = 8;
    localparam logic PAR_EVEN = 1'b1;
    localparam logic PAR_ODD  = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake bundle between the TX byte source, the parity calculator and the
// UART transmit controller.
//   p_data/data_valid/par_en/par_type : byte request from the source
//   parity_i                          : registered parity bit from the calculator
//   parity_data/parity_type/parity_en : latched byte, type and capture strobe to the calculator
//   tx_out                            : serial line, idle high
//   busy                              : frame in flight
// master = environment side (source + parity calculator), slave = controller.
interface uart_tx_ctrl_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] p_data;
    logic              data_valid;
    logic              par_en;
    logic              par_type;
    logic              parity_i;
    logic [DATA_W-1:0] parity_data;
    logic              parity_type;
    logic              parity_en;
    logic              tx_out;
    logic              busy;

    modport master (
        output p_data, data_valid, par_en, par_type, parity_i,
        input  parity_data, parity_type, parity_en, tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_type, parity_i,
        output parity_data, parity_type, parity_en, tx_out, busy
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Serial bit period timer. Down-counter reloaded with CLKS_PER_BIT-1 on restart
// and on every terminal count, so bit_done ticks once every CLKS_PER_BIT cycles
// while en is high.
//   clk      : clock
//   rst      : synchronous reset, active high
//   restart  : reload counter (start of a frame)
//   en       : count enable (frame in flight)
//   bit_done : one-cycle tick on the last cycle of a bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    output logic bit_done
);

    localparam int             CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    assign bit_done = en && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (restart || bit_done) begin
            cnt_q <= RELOAD;
        end else if (en) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller. Accepts one byte per handshake while idle and
// shifts it out LSB-first as start, 8 data bits, optional parity, stop.
//   clk  : clock, all logic on posedge
//   rst  : synchronous reset, active high; aborts any frame, line returns high
//   bus  : uart_tx_ctrl_if.slave (byte request, parity calculator link, tx_out, busy)
//
// state  | meaning
// IDLE   | line high, waiting for data_valid
// START  | start bit (low)
// DATA   | data bit idx_q of the latched byte
// PARITY | parity bit returned by the calculator (only when par_en latched)
// STOP   | stop bit (high); returns to IDLE at its end
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus
);

    localparam int            IW       = $clog2(DATA_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    uart_state_e       state_q, state_nxt;
    logic [IW-1:0]     idx_q, idx_nxt, idx_inc;
    logic [DATA_W-1:0] data_q;
    logic              par_en_q;
    logic              par_type_q;
    logic              par_pulse_q;
    logic              tx_q, tx_nxt;
    logic              accept;
    logic              bit_done;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (accept),
        .en       (state_q != IDLE),
        .bit_done (bit_done)
    );

    assign idx_inc = idx_q + IW'(1);

    // tx_nxt is the line level for the state being entered, so the registered
    // tx_out changes on the same edge as the state.
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        tx_nxt    = tx_q;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_nxt = 1'b1;
                if (bus.data_valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                    idx_nxt   = '0;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nxt = DATA;
                    idx_nxt   = '0;
                    tx_nxt    = data_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == LAST_IDX) begin
                        if (par_en_q) begin
                            state_nxt = PARITY;
                            tx_nxt    = bus.parity_i;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        idx_nxt = idx_inc;
                        tx_nxt  = data_q[idx_inc];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            par_type_q  <= 1'b0;
            par_pulse_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_nxt;
            idx_q       <= idx_nxt;
            tx_q        <= tx_nxt;
            par_pulse_q <= accept;
            if (accept) begin
                data_q     <= bus.p_data;
                par_en_q   <= bus.par_en;
                par_type_q <= bus.par_type;
            end
        end
    end

    assign bus.tx_out      = tx_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.parity_data = data_q;
    assign bus.parity_type = par_type_q;
    assign bus.parity_en   = par_pulse_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int C = 4;

    logic clk;
    logic rst;
    logic par_reg;

    int checks   = 0;
    int failures = 0;

    logic       exp_q[$];
    int         len_q[$];
    logic [7:0] exp_byte_q[$];
    logic       exp_pt_q[$];

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // parity calculator model: captures on the strobe, holds the result
    always @(posedge clk) begin
        if (rst) par_reg <= 1'b0;
        else if (bus.parity_en)
            par_reg <= (bus.parity_type == PAR_EVEN) ? ^bus.parity_data : ~^bus.parity_data;
    end
    assign bus.parity_i = par_reg;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic exp_parity(input logic [7:0] b, input logic pt);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        if (pt == PAR_EVEN) return (ones % 2) == 1;
        else                return (ones % 2) == 0;
    endfunction

    task automatic push_frame(input logic [7:0] b, input logic pe, input logic pt);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (pe) exp_q.push_back(exp_parity(b, pt));
        exp_q.push_back(1'b1);
        len_q.push_back((pe ? 11 : 10) * C);
        exp_byte_q.push_back(b);
        exp_pt_q.push_back(pt);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b required 0 after %0d cycles", bus.busy, n);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pe, input logic pt, input logic hold);
        wait_idle();
        @(negedge clk);
        bus.p_data     = b;
        bus.par_en     = pe;
        bus.par_type   = pt;
        bus.data_valid = 1'b1;
        push_frame(b, pe, pt);
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.tx_out !== 1'b0) begin
            failures++;
            $display("FAIL accept_%02h: busy=%b tx_out=%b required busy=1 tx_out=0", b, bus.busy, bus.tx_out);
        end
        if (!hold) bus.data_valid = 1'b0;
    endtask

    // Called right after the accept edge; pops one frame from the scoreboard.
    task automatic check_frame(input string name, input int poke_cycle);
        int         len;
        int         nbits;
        int         cyc;
        logic [7:0] eb;
        logic       ept;
        logic       bit_exp;
        logic       bit_ok;
        logic       act;
        logic       busy_bad;
        logic       pen_bad;
        if (len_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got 0 frames required 1", name);
            return;
        end
        len      = len_q.pop_front();
        eb       = exp_byte_q.pop_front();
        ept      = exp_pt_q.pop_front();
        nbits    = len / C;
        cyc      = 0;
        busy_bad = 1'b0;
        pen_bad  = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            bit_exp = exp_q.pop_front();
            bit_ok  = 1'b1;
            act     = bit_exp;
            for (int k = 0; k < C; k++) begin
                @(negedge clk);
                if (bus.tx_out !== bit_exp) begin
                    bit_ok = 1'b0;
                    act    = bus.tx_out;
                end
                if (bus.busy !== 1'b1) busy_bad = 1'b1;
                if (bus.parity_en !== (cyc == 0)) pen_bad = 1'b1;
                if (cyc == poke_cycle) begin
                    bus.p_data     = 8'hFF;
                    bus.par_en     = ~bus.par_en;
                    bus.par_type   = ~bus.par_type;
                    bus.data_valid = 1'b1;
                end else if (poke_cycle >= 0 && cyc == poke_cycle + 1) begin
                    bus.data_valid = 1'b0;
                end
                cyc++;
            end
            checks++;
            if (!bit_ok) begin
                failures++;
                $display("FAIL %s_bit%0d: tx_out=%b required %b", name, b, act, bit_exp);
            end
        end
        checks++;
        if (busy_bad) begin
            failures++;
            $display("FAIL %s_busy: busy dropped before %0d cycles", name, len);
        end
        checks++;
        if (pen_bad) begin
            failures++;
            $display("FAIL %s_parity_en: strobe not exactly one cycle after accept", name);
        end
        checks++;
        if (bus.parity_data !== eb || bus.parity_type !== ept) begin
            failures++;
            $display("FAIL %s_latch: parity_data=%02h parity_type=%b required %02h %b",
                     name, bus.parity_data, bus.parity_type, eb, ept);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_out !== 1'b1) begin
            failures++;
            $display("FAIL %s_end: busy=%b tx_out=%b required busy=0 tx_out=1 after %0d cycles",
                     name, bus.busy, bus.tx_out, len);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0 || bus.parity_en !== 1'b0) begin
            failures++;
            $display("FAIL reset: tx_out=%b busy=%b parity_en=%b required 1 0 0",
                     bus.tx_out, bus.busy, bus.parity_en);
        end
        checks++;
        if (bus.parity_data !== 8'h00 || bus.parity_type !== 1'b0) begin
            failures++;
            $display("FAIL reset_latch: parity_data=%02h parity_type=%b required 00 0",
                     bus.parity_data, bus.parity_type);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h00, 1'b0, PAR_ODD, 1'b0);
        exp_q.delete();
        len_q.delete();
        exp_byte_q.delete();
        exp_pt_q.delete();
        repeat (3 * C) @(negedge clk);
        checks++;
        if (bus.tx_out !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_data: tx_out=%b busy=%b required 0 1", bus.tx_out, bus.busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: tx_out=%b busy=%b required 1 0", bus.tx_out, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_no_parity();
        send_byte(8'hA5, 1'b0, PAR_ODD, 1'b0);
        check_frame("a5_nopar", -1);
    endtask

    task automatic test_parity();
        send_byte(8'hA5, 1'b1, PAR_EVEN, 1'b0);
        check_frame("a5_even", -1);
        send_byte(8'h01, 1'b1, PAR_ODD, 1'b0);
        check_frame("01_odd", -1);
        send_byte(8'h03, 1'b1, PAR_ODD, 1'b0);
        check_frame("03_odd", -1);
    endtask

    task automatic test_ignore_busy();
        send_byte(8'hA5, 1'b0, PAR_ODD, 1'b0);
        check_frame("ignore", 9);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_out !== 1'b1) begin
            failures++;
            $display("FAIL ignore_queue: busy=%b tx_out=%b required 0 1", bus.busy, bus.tx_out);
        end
    endtask

    task automatic test_back_to_back();
        send_byte(8'h55, 1'b0, PAR_ODD, 1'b1);
        bus.p_data = 8'h0F;
        push_frame(8'h0F, 1'b0, PAR_ODD);
        check_frame("b2b_55", -1);
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.tx_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: busy=%b tx_out=%b required 1 0 after one idle cycle",
                     bus.busy, bus.tx_out);
        end
        bus.data_valid = 1'b0;
        check_frame("b2b_0f", -1);
    endtask

    initial begin
        rst            = 1'b1;
        bus.p_data     = 8'h00;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_type   = PAR_ODD;
        test_reset();
        test_no_parity();
        test_parity();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_no_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
